// File: rtl/resend_q_pkg.sv
// resend_q_pkg: shared ring slot-type codes and din field positions
package resend_q_pkg;
  localparam int DEST_MSB = 39;
  localparam int TYPE_MSB = 35;
  localparam int DATA_MSB = 31;
  typedef enum logic [3:0] {
    SLOT_EMPTY  = 4'h0,
    SLOT_DATA   = 4'h1,
    SLOT_ADDR   = 4'h2,
    SLOT_ACK    = 4'h3,
    SLOT_RESEND = 4'h6
  } slot_type_e;
  function automatic logic [DEST_MSB:0] pack_entry(logic [3:0] dest, slot_type_e t, logic [DATA_MSB:0] data);
    return {dest, t, data};
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit read/write pointers with registered-pointer full/empty flags
// Ports: clk, rst (async active-low), wr_en/rd_en requests in; wr_go/rd_go accepted
// operations, wr_addr/rd_addr storage addresses, full/empty flags out.
module fifo_ptr
  import resend_q_pkg::*;
#(
  parameter int LOGSIZE = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic               wr_go,
  output logic               rd_go,
  output logic [LOGSIZE-1:0] wr_addr,
  output logic [LOGSIZE-1:0] rd_addr,
  output logic               full,
  output logic               empty
);
  logic [LOGSIZE:0] wr_q, wr_d, rd_q, rd_d;
  assign wr_addr = wr_q[LOGSIZE-1:0];
  assign rd_addr = rd_q[LOGSIZE-1:0];
  assign empty = wr_q == rd_q;
  // Same slot, opposite lap: the writer is exactly one lap ahead.
  assign full = (wr_q[LOGSIZE] != rd_q[LOGSIZE]) && (wr_addr == rd_addr);
  always_comb begin
    // A full queue still accepts a write when the head leaves on the same edge.
    wr_go = wr_en && (!full || rd_en);
    rd_go = rd_en && !empty;
    wr_d = wr_q + {{LOGSIZE{1'b0}}, wr_go};
    rd_d = rd_q + {{LOGSIZE{1'b0}}, rd_go};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/resend_q.sv
// resend_q: show-ahead FIFO holding ring entries awaiting resend
// Ports: clk, rst (async active-low), din/wr_en push, rd_en pop,
// dout head entry (valid when empty=0), full, empty.
module resend_q
  import resend_q_pkg::*;
#(
  parameter int WIDTH   = 40,
  parameter int LOGSIZE = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [LOGSIZE-1:0] wr_addr, rd_addr;
  logic               wr_go, rd_go;
  logic [WIDTH-1:0]   mem_q [2**LOGSIZE];
  fifo_ptr #(.LOGSIZE(LOGSIZE)) u_ptr (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .wr_go(wr_go), .rd_go(rd_go), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .full(full), .empty(empty)
  );
  // Storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_addr] <= din;
  end
  // Asynchronous read gives first-word fall-through.
  assign dout = mem_q[rd_addr];
endmodule

// File: tb/tb_resend_q.sv
// tb_resend_q: directed and streaming checks of resend_q against a queue model
module tb_resend_q;
  localparam int DEPTH = 64;
  logic        clk = 0;
  logic        rst = 0;
  logic [39:0] din = '0;
  logic        wr_en = 0;
  logic        rd_en = 0;
  logic [39:0] dout;
  logic        full, empty;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic [39:0] model[$];

  resend_q dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Queue model: a pop needs something queued; a push needs room or a same-edge pop.
  always @(posedge clk or negedge rst) begin
    if (!rst) model.delete();
    else begin
      bit do_rd, do_wr;
      do_rd = rd_en && model.size() > 0;
      do_wr = wr_en && (model.size() < DEPTH || rd_en);
      if (do_rd) begin
        void'(model.pop_front());
        pops++;
      end
      if (do_wr) model.push_back(din);
    end
  end

  always @(negedge clk) begin
    chk("empty", {39'd0, empty}, {39'd0, model.size() == 0});
    chk("full", {39'd0, full}, {39'd0, model.size() == DEPTH});
    if (model.size() > 0) chk("dout", dout, model[0]);
  end

  task automatic cyc(input logic w, input logic r, input logic [39:0] d);
    wr_en = w;
    rd_en = r;
    din = d;
    @(negedge clk);
    wr_en = 0;
    rd_en = 0;
  endtask

  initial begin
    int p0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_empty", {39'd0, empty}, 40'd1);
    chk("rst_full", {39'd0, full}, 40'd0);
    rst = 1;
    cyc(1, 0, 40'h620000ABCD);
    chk("fwft_empty", {39'd0, empty}, 40'd0);
    chk("fwft_dout", dout, 40'h620000ABCD);
    cyc(0, 1, 0);
    chk("pop1_empty", {39'd0, empty}, 40'd1);
    for (int i = 0; i < 64; i++) cyc(1, 0, 40'(i));
    chk("fill_full", {39'd0, full}, 40'd1);
    cyc(1, 0, 40'hFF);
    chk("drop_full", {39'd0, full}, 40'd1);
    for (int i = 0; i < 64; i++) begin
      chk("drain_order", dout, 40'(i));
      cyc(0, 1, 0);
    end
    chk("drain_empty", {39'd0, empty}, 40'd1);
    for (int i = 0; i < 64; i++) cyc(1, 0, 40'(i));
    cyc(1, 1, 40'h99);
    chk("rw_full", {39'd0, full}, 40'd1);
    for (int i = 1; i < 64; i++) begin
      chk("rw_order", dout, 40'(i));
      cyc(0, 1, 0);
    end
    chk("rw_last", dout, 40'h99);
    cyc(0, 1, 0);
    chk("rw_empty", {39'd0, empty}, 40'd1);
    cyc(1, 1, 40'h55);
    chk("rwe_empty", {39'd0, empty}, 40'd0);
    chk("rwe_dout", dout, 40'h55);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("rde_empty", {39'd0, empty}, 40'd1);
    chk("rde_full", {39'd0, full}, 40'd0);
    cyc(1, 0, 40'h3);
    chk("rde_next", dout, 40'h3);
    for (int i = 0; i < 10; i++) cyc(1, 0, 40'(i + 16));
    #2 rst = 0;
    #1;
    chk("async_empty", {39'd0, empty}, 40'd1);
    chk("async_full", {39'd0, full}, 40'd0);
    @(negedge clk);
    cyc(1, 1, 40'h44);
    chk("rst_held", {39'd0, empty}, 40'd1);
    rst = 1;
    cyc(1, 0, 40'h7);
    chk("post_rst", dout, 40'h7);
    cyc(0, 1, 0);
    p0 = pops;
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, {8'h0, $urandom});
    chk("wrap3", {39'd0, (pops - p0) >= 3 * DEPTH}, 40'd1);
    while (model.size() > 0) cyc(0, 1, 0);
    chk("end_empty", {39'd0, empty}, 40'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
